// File: rtl/mux_pkg.sv
// mux_pkg: shared constants for the registered 8:1 selector.
//   SEL_A..SEL_H : select encodings {s2,s1,s} for inputs a..h
//   MUX_RST_VAL  : per-bit value loaded into the output register on reset
package mux_pkg;

  localparam logic [2:0] SEL_A = 3'd0;
  localparam logic [2:0] SEL_B = 3'd1;
  localparam logic [2:0] SEL_C = 3'd2;
  localparam logic [2:0] SEL_D = 3'd3;
  localparam logic [2:0] SEL_E = 3'd4;
  localparam logic [2:0] SEL_F = 3'd5;
  localparam logic [2:0] SEL_G = 3'd6;
  localparam logic [2:0] SEL_H = 3'd7;

  localparam logic MUX_RST_VAL = 1'b0;

endpackage

// File: rtl/mux_2x1.sv
// mux_2x1: purely combinational 2:1 selector, one leaf of the selection tree.
//   i0  : data returned when sel = 0
//   i1  : data returned when sel = 1
//   sel : select
//   y   : selected data
module mux_2x1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? i1 : i0;

endmodule

// File: rtl/mux8x1.sv
// mux8x1: registered 8:1 selector built from a three-level 2:1 tree.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, clears out
//   a..h       : data inputs 0..7
//   s, s1, s2  : select bits 0 (LSB), 1, 2 (MSB)
//   out        : registered selected data, one cycle after sampling
module mux8x1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic             s,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] in_w [8];
  logic [WIDTH-1:0] l1_w [4];
  logic [WIDTH-1:0] l2_w [2];
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  assign in_w[0] = a;
  assign in_w[1] = b;
  assign in_w[2] = c;
  assign in_w[3] = d;
  assign in_w[4] = e;
  assign in_w[5] = f;
  assign in_w[6] = g;
  assign in_w[7] = h;

  // Level 1: adjacent pairs (a,b),(c,d),(e,f),(g,h) steered by the LSB.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_l1
      mux_2x1 #(.WIDTH(WIDTH)) u_mux (
        .i0 (in_w[2*gi]),
        .i1 (in_w[2*gi+1]),
        .sel(s),
        .y  (l1_w[gi])
      );
    end

    // Level 2: pairs of level-1 results steered by s1.
    for (gi = 0; gi < 2; gi++) begin : g_l2
      mux_2x1 #(.WIDTH(WIDTH)) u_mux (
        .i0 (l1_w[2*gi]),
        .i1 (l1_w[2*gi+1]),
        .sel(s1),
        .y  (l2_w[gi])
      );
    end
  endgenerate

  // Level 3: final choice between the low and high halves.
  mux_2x1 #(.WIDTH(WIDTH)) u_l3 (
    .i0 (l2_w[0]),
    .i1 (l2_w[1]),
    .sel(s2),
    .y  (out_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= {WIDTH{MUX_RST_VAL}};
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mux8x1.sv
// tb_mux8x1: directed checks of mux8x1 at WIDTH=1 and WIDTH=8.
module tb_mux8x1;

  logic       clk;
  logic       rst;
  logic       a, b, c, d, e, f, g, h;
  logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;
  logic       s, s1, s2;
  logic       out1;
  logic [7:0] out8;

  int checks   = 0;
  int failures = 0;

  mux8x1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .s(s), .s1(s1), .s2(s2),
    .out(out1)
  );

  mux8x1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .a(a8), .b(b8), .c(c8), .d(d8), .e(e8), .f(f8), .g(g8), .h(h8),
    .s(s), .s1(s1), .s2(s2),
    .out(out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp, input bit show);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    if (show) $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_sel(input logic [2:0] v);
    {s2, s1, s} = v;
  endtask

  task automatic set_narrow(input logic [7:0] v);
    {h, g, f, e, d, c, b, a} = v;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [10:0] vec;
    logic [7:0]  dat;
    logic [2:0]  sl;
    logic [7:0]  wide_exp [8];

    wide_exp[0] = 8'h11; wide_exp[1] = 8'h22; wide_exp[2] = 8'h33; wide_exp[3] = 8'h44;
    wide_exp[4] = 8'h55; wide_exp[5] = 8'h66; wide_exp[6] = 8'h77; wide_exp[7] = 8'h88;

    // Power-on reset
    rst = 1'b1;
    set_narrow(8'h00);
    {a8, b8, c8, d8, e8, f8, g8, h8} = '0;
    set_sel(3'd0);
    #2;
    check("por_out1", {7'b0, out1}, 8'h00, 1'b1);
    check("por_out8", out8, 8'h00, 1'b1);
    edge_sample();
    check("por_hold", {7'b0, out1}, 8'h00, 1'b1);
    rst = 1'b0;

    // Reset between edges with a=1, h=1, sel=7
    set_narrow(8'h81);
    set_sel(3'd7);
    edge_sample();
    check("pre_rst_load", {7'b0, out1}, 8'h01, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst", {7'b0, out1}, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check("rst_hold", {7'b0, out1}, 8'h00, 1'b1);
    end
    rst = 1'b0;
    edge_sample();
    check("rst_release_load", {7'b0, out1}, 8'h01, 1'b1);

    // Per-input walk
    for (int k = 0; k < 8; k++) begin
      set_narrow(8'h01 << k);
      for (int j = 0; j < 8; j++) begin
        sl = 3'(j);
        set_sel(sl);
        edge_sample();
        check($sformatf("walk_in%0d_sel%0d", k, j), {7'b0, out1},
              (j == k) ? 8'h01 : 8'h00, 1'b1);
      end
    end

    // Exhaustive sweep of {s2,s1,s,h..a}
    for (int v = 0; v < 2048; v++) begin
      vec = 11'(v);
      {s2, s1, s, h, g, f, e, d, c, b, a} = vec;
      edge_sample();
      dat = vec[7:0];
      sl  = vec[10:8];
      check($sformatf("exh_%03h", vec), {7'b0, out1}, {7'b0, dat[sl]}, 1'b0);
    end
    $display("check exhaustive sweep done, 2048 vectors");

    // Latency: a=1, b=0, toggle s
    set_narrow(8'h01);
    s2 = 1'b0;
    s1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s = i[0];
      edge_sample();
      check($sformatf("lat_%0d", i), {7'b0, out1}, {7'b0, ~s}, 1'b1);
    end

    // Wide data sweep
    a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;
    e8 = 8'h55; f8 = 8'h66; g8 = 8'h77; h8 = 8'h88;
    for (int j = 0; j < 8; j++) begin
      set_sel(3'(j));
      edge_sample();
      check($sformatf("wide_sel%0d", j), out8, wide_exp[j], 1'b1);
    end

    // Mid-run reset pulse during a sweep
    for (int j = 0; j < 8; j++) begin
      set_sel(3'(j));
      edge_sample();
      check($sformatf("midrun_sel%0d", j), out8, wide_exp[j], 1'b1);
      if (j == 4) begin
        #1 rst = 1'b1;
        #1;
        check("midrun_rst", out8, 8'h00, 1'b1);
        #2 rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
